// File: rtl/decoder_scan_seq.sv
// Registered N-to-2^N one-hot line selector with DIRECT (hold) and SCAN
// (auto-stepping, DWELL cycles per line) modes.
module decoder_scan_seq #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            En,
  input  logic            mode,
  input  logic            load,
  input  logic [N-1:0]    I,
  output logic [2**N-1:0] Y,
  output logic [N-1:0]    idx,
  output logic            busy,
  output logic            wrap
);

  localparam int OUTS = 2**N;
  localparam int DW   = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      idx_q,   idx_d;
  logic [DW-1:0]     cnt_q,   cnt_d;
  logic [OUTS-1:0]   y_q,     y_d;
  logic              busy_q,  busy_d;
  logic              wrap_q,  wrap_d;
  logic [N-1:0]      idx_inc;

  function automatic logic [OUTS-1:0] one_hot(input logic [N-1:0] sel);
    logic [OUTS-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  assign idx_inc = idx_q + N'(1);

  // Priority: En low > load > dwell step; idx survives a drop to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    if (!En) begin
      state_d = IDLE;
      y_d     = '0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (load) begin
      idx_d   = I;
      cnt_d   = '0;
      y_d     = one_hot(I);
      state_d = mode ? SCAN : HOLD;
      busy_d  = mode;
    end else if (state_q == SCAN) begin
      if (cnt_q == DW'(DWELL - 1)) begin
        idx_d  = idx_inc;
        cnt_d  = '0;
        y_d    = one_hot(idx_inc);
        wrap_d = (idx_q == '1);
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y    = y_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: a DWELL=4 and a DWELL=1 instance share stimulus
// and are checked against a cycles-since-load model of the scan position.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst, En, mode, load;
  logic [2:0] I;
  logic [7:0] y0, y1;
  logic [2:0] idx0, idx1;
  logic       busy0, busy1, wrap0, wrap1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: 0 idle, 1 hold, 2 scan; position derived from start + elapsed/dwell.
  int active;
  int start;
  int t;
  int lastidx [2];
  int dw      [2] = '{4, 1};

  decoder_scan_seq #(.N(3), .DWELL(4)) dut0 (
    .clk(clk), .rst(rst), .En(En), .mode(mode), .load(load), .I(I),
    .Y(y0), .idx(idx0), .busy(busy0), .wrap(wrap0)
  );

  decoder_scan_seq #(.N(3), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .En(En), .mode(mode), .load(load), .I(I),
    .Y(y1), .idx(idx1), .busy(busy1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int cur_idx(input int k);
    if (active == 2) return (start + t / dw[k]) % 8;
    if (active == 1) return start;
    return lastidx[k];
  endfunction

  task automatic model_reset();
    active     = 0;
    start      = 0;
    t          = 0;
    lastidx[0] = 0;
    lastidx[1] = 0;
  endtask

  task automatic model_edge();
    if (!En) begin
      lastidx[0] = cur_idx(0);
      lastidx[1] = cur_idx(1);
      active     = 0;
    end else if (load) begin
      start      = int'(I);
      t          = 0;
      active     = mode ? 2 : 1;
      lastidx[0] = start;
      lastidx[1] = start;
    end else if (active == 2) begin
      t++;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int          e;
      logic [31:0] ey, ew, eb;
      e  = cur_idx(k);
      ey = (active != 0) ? (32'd1 << e) : 32'd0;
      eb = (active == 2) ? 32'd1 : 32'd0;
      ew = (active == 2 && t > 0 && (t % dw[k]) == 0 && e == 0) ? 32'd1 : 32'd0;
      if (k == 0) begin
        check_val("Y_d4",    32'(y0),    ey);
        check_val("idx_d4",  32'(idx0),  32'(e));
        check_val("busy_d4", 32'(busy0), eb);
        check_val("wrap_d4", 32'(wrap0), ew);
        check_val("onehot0_d4", 32'($onehot0(y0)), 32'd1);
      end else begin
        check_val("Y_d1",    32'(y1),    ey);
        check_val("idx_d1",  32'(idx1),  32'(e));
        check_val("busy_d1", 32'(busy1), eb);
        check_val("wrap_d1", 32'(wrap1), ew);
        check_val("onehot0_d1", 32'($onehot0(y1)), 32'd1);
      end
    end
  endtask

  task automatic step(input logic en_v, input logic mode_v, input logic load_v, input logic [2:0] i_v);
    En   = en_v;
    mode = mode_v;
    load = load_v;
    I    = i_v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int j = 0; j < n; j++) step(1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  // Called at a negedge: pulse rst between edges and check it acts at once.
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; En = 1'b0; mode = 1'b0; load = 1'b0; I = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 3'(i));
      idle_steps(1);
    end

    step(1'b1, 1'b1, 1'b1, 3'd6);
    idle_steps(14);

    idle_steps(1);
    step(1'b1, 1'b1, 1'b1, 3'd2);
    idle_steps(5);
    step(1'b1, 1'b0, 1'b1, 3'd5);
    idle_steps(3);

    step(1'b1, 1'b1, 1'b1, 3'd3);
    idle_steps(2);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b1, 3'd1);
    idle_steps(3);

    step(1'b1, 1'b1, 1'b1, 3'd4);
    idle_steps(3);
    async_reset_pulse();
    idle_steps(3);

    step(1'b1, 1'b1, 1'b1, 3'd0);
    idle_steps(20);

    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 99) < 2) async_reset_pulse();
      step(($urandom_range(0, 99) < 92) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
